// File: rtl/touch_region_pkg.sv
// Shared types and helpers for the touch-driven region colour table.
package touch_region_pkg;

  localparam int unsigned NUM_REGIONS = 8;
  localparam int unsigned REGION_W    = 3;
  localparam int unsigned COLOUR_W    = 3;
  localparam int unsigned COORD_W     = 12;

  typedef logic [REGION_W-1:0] region_t;
  typedef logic [COLOUR_W-1:0] colour_t;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOCK    = 2'd1,
    S_RELEASE = 2'd2
  } tr_state_t;

  typedef struct packed {
    region_t region;
    colour_t colour;
  } host_wr_t;

  // Power-up colour of each region is its own index.
  function automatic colour_t default_colour(input region_t r);
    return colour_t'(r);
  endfunction

endpackage

// File: rtl/lockout_timer.sv
// Down-counter that holds off repeat touch commits after a commit.
module lockout_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             clear_i,
  input  logic [WIDTH-1:0] value_i,
  output logic             done_c
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (load_i) begin
      count_d = value_i;
    end else if (count_q != '0) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done_c = (count_q == '0);

endmodule

// File: rtl/touch_region_controller.sv
// Touch-event sequencer for an 8-entry region colour table with a host write
// port, clear, and a press lockout window.
module touch_region_controller
  import touch_region_pkg::*;
#(
  parameter int unsigned LOCKOUT_CYCLES = 2500000,
  parameter int unsigned CNT_W          = 8
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             Coord_En,
  input  logic             Touch_En,
  input  logic [11:0]      X_Coord,
  input  logic [11:0]      Y_Coord,
  input  logic             Clear_Req,
  input  logic             Host_Wr,
  input  logic [2:0]       Host_Region,
  input  logic [2:0]       Host_Colour,
  output logic             Host_Ack,
  input  logic [2:0]       Rd_Region,
  output logic [2:0]       Rd_Colour,
  output logic [2:0]       Last_Region,
  output logic [CNT_W-1:0] Event_Count,
  output logic             Busy
);

  localparam int unsigned      TMR_W    = $clog2(LOCKOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0] LOAD_VAL = TMR_W'(LOCKOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  tr_state_t        state_q, state_d;
  logic             coord_buf_q;
  logic             coord_rise_c, commit_c, host_acc_c, tmr_done_c;
  region_t          touch_region_c;
  host_wr_t         host_c;
  colour_t          table_q [NUM_REGIONS];
  colour_t          table_d [NUM_REGIONS];
  region_t          last_region_q, last_region_d;
  logic [CNT_W-1:0] event_cnt_q, event_cnt_d;
  logic             host_ack_q, busy_q;
  logic             unused_coord_c;

  assign coord_rise_c   = Coord_En & ~coord_buf_q;
  assign touch_region_c = {Y_Coord[11], X_Coord[11:10]};
  assign host_c         = {Host_Region, Host_Colour};
  assign unused_coord_c = ^{X_Coord[9:0], Y_Coord[10:0]};

  lockout_timer #(.WIDTH(TMR_W)) u_lockout (
    .clk     (Clock),
    .rst_n   (Resetn),
    .load_i  (commit_c),
    .clear_i (Clear_Req),
    .value_i (LOAD_VAL),
    .done_c  (tmr_done_c)
  );

  // Press FSM; clear overrides both the transition and any commit.
  always_comb begin
    state_d  = state_q;
    commit_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (coord_rise_c) begin
          commit_c = 1'b1;
          state_d  = S_LOCK;
        end
      end
      S_LOCK:    if (tmr_done_c) state_d = S_RELEASE;
      S_RELEASE: if (!Touch_En)  state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    if (Clear_Req) begin
      commit_c = 1'b0;
      state_d  = S_IDLE;
    end
  end

  assign host_acc_c = Host_Wr & ~Clear_Req & ~commit_c;

  // Single table write port: clear > touch commit > host write.
  always_comb begin
    table_d       = table_q;
    last_region_d = last_region_q;
    event_cnt_d   = event_cnt_q;
    if (Clear_Req) begin
      for (int unsigned i = 0; i < NUM_REGIONS; i++) begin
        table_d[i] = default_colour(region_t'(i));
      end
      event_cnt_d = '0;
    end else if (commit_c) begin
      table_d[touch_region_c] = table_q[touch_region_c] + colour_t'(1);
      last_region_d           = touch_region_c;
      if (event_cnt_q != CNT_MAX) begin
        event_cnt_d = event_cnt_q + CNT_W'(1);
      end
    end else if (host_acc_c) begin
      table_d[host_c.region] = host_c.colour;
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q       <= S_IDLE;
      coord_buf_q   <= 1'b0;
      last_region_q <= '0;
      event_cnt_q   <= '0;
      host_ack_q    <= 1'b0;
      busy_q        <= 1'b0;
      for (int unsigned i = 0; i < NUM_REGIONS; i++) begin
        table_q[i] <= default_colour(region_t'(i));
      end
    end else begin
      state_q       <= state_d;
      coord_buf_q   <= Coord_En;
      last_region_q <= last_region_d;
      event_cnt_q   <= event_cnt_d;
      host_ack_q    <= host_acc_c;
      busy_q        <= (state_d != S_IDLE);
      table_q       <= table_d;
    end
  end

  assign Rd_Colour   = table_q[Rd_Region];
  assign Last_Region = last_region_q;
  assign Event_Count = event_cnt_q;
  assign Host_Ack    = host_ack_q;
  assign Busy        = busy_q;

endmodule

// File: tb/tb_touch_region_controller.sv
// Self-checking bench for touch_region_controller: directed scenarios, a
// region-decode vector table and randomized traffic against a timestamp model.
module tb_touch_region_controller;

  localparam int unsigned L     = 16;
  localparam int unsigned CNT_W = 8;

  logic             Clock;
  logic             Resetn;
  logic             Coord_En, Touch_En;
  logic [11:0]      X_Coord, Y_Coord;
  logic             Clear_Req, Host_Wr;
  logic [2:0]       Host_Region, Host_Colour;
  logic             Host_Ack;
  logic [2:0]       Rd_Region, Rd_Colour, Last_Region;
  logic [CNT_W-1:0] Event_Count;
  logic             Busy;

  touch_region_controller #(.LOCKOUT_CYCLES(L), .CNT_W(CNT_W)) dut (
    .Clock       (Clock),
    .Resetn      (Resetn),
    .Coord_En    (Coord_En),
    .Touch_En    (Touch_En),
    .X_Coord     (X_Coord),
    .Y_Coord     (Y_Coord),
    .Clear_Req   (Clear_Req),
    .Host_Wr     (Host_Wr),
    .Host_Region (Host_Region),
    .Host_Colour (Host_Colour),
    .Host_Ack    (Host_Ack),
    .Rd_Region   (Rd_Region),
    .Rd_Colour   (Rd_Colour),
    .Last_Region (Last_Region),
    .Event_Count (Event_Count),
    .Busy        (Busy)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: table contents, counters, and the press window kept as
  // "idle" plus the cycle at which the lockout ends.
  int m_tab [8];
  int m_last, m_cnt, m_unlock_at, cyc;
  bit m_ack, m_idle, m_buf;

  typedef struct {
    logic [11:0] x;
    logic [11:0] y;
    int          region;
    int          colour;
  } vec_t;
  vec_t vecs [10];

  function automatic void check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < 8; i++) m_tab[i] = i;
    m_last = 0; m_cnt = 0; m_ack = 1'b0; m_idle = 1'b1; m_buf = 1'b0; m_unlock_at = 0;
  endfunction

  function automatic int region_of(input int x, input int y);
    return ((y >= 2048) ? 4 : 0) + (x / 1024);
  endfunction

  task automatic check_outputs();
    check("rd_colour",   int'(Rd_Colour),   m_tab[Rd_Region]);
    check("last_region", int'(Last_Region), m_last);
    check("event_count", int'(Event_Count), m_cnt);
    check("host_ack",    int'(Host_Ack),    m_ack ? 1 : 0);
    check("busy",        int'(Busy),        m_idle ? 0 : 1);
  endtask

  // One clock: evaluate the model on pre-edge inputs, then compare after the edge.
  task automatic tick();
    bit rise, commit, host, rel, te, ce, clr;
    int r, hr, hc;
    ce     = Coord_En;
    te     = Touch_En;
    clr    = Clear_Req;
    rise   = ce && !m_buf;
    commit = m_idle && rise && !clr;
    host   = Host_Wr && !clr && !commit;
    rel    = !m_idle && (cyc >= m_unlock_at);
    r      = region_of(int'(X_Coord), int'(Y_Coord));
    hr     = int'(Host_Region);
    hc     = int'(Host_Colour);
    @(posedge Clock);
    if (clr) begin
      for (int i = 0; i < 8; i++) m_tab[i] = i;
      m_cnt  = 0;
      m_idle = 1'b1;
    end else if (commit) begin
      m_tab[r]    = (m_tab[r] + 1) % 8;
      m_last      = r;
      if (m_cnt < 255) m_cnt++;
      m_idle      = 1'b0;
      m_unlock_at = cyc + 1 + int'(L);
    end else begin
      if (host) m_tab[hr] = hc;
      if (rel && !te) m_idle = 1'b1;
    end
    m_ack = host;
    m_buf = ce;
    cyc++;
    #1;
    check_outputs();
  endtask

  task automatic rd_check(input int r, input int exp, input string name);
    Rd_Region = 3'(r);
    #1;
    check(name, int'(Rd_Colour), exp);
  endtask

  task automatic check_table();
    for (int r = 0; r < 8; r++) begin
      Rd_Region = 3'(r);
      #1;
      check("table_entry", int'(Rd_Colour), m_tab[r]);
    end
  endtask

  task automatic do_reset();
    Resetn = 1'b0;
    #1;
    check("rst_async_busy",  int'(Busy),        0);
    check("rst_async_count", int'(Event_Count), 0);
    m_reset();
    @(posedge Clock);
    #1;
    check_table();
    @(negedge Clock);
    Resetn = 1'b1;
    #1;
    check("rst_busy",  int'(Busy),        0);
    check("rst_count", int'(Event_Count), 0);
    check("rst_last",  int'(Last_Region), 0);
    check("rst_ack",   int'(Host_Ack),    0);
  endtask

  task automatic wait_idle();
    int k;
    Touch_En = 1'b0;
    k = 0;
    while (Busy && k < 64) begin
      tick();
      k++;
    end
    if (Busy) check("idle_timeout", int'(Busy), 0);
  endtask

  task automatic touch();
    Coord_En = 1'b1;
    tick();
    Coord_En = 1'b0;
    wait_idle();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    int busy_cnt;
    Resetn = 1'b0; Coord_En = 1'b0; Touch_En = 1'b0;
    X_Coord = '0; Y_Coord = '0; Clear_Req = 1'b0; Host_Wr = 1'b0;
    Host_Region = '0; Host_Colour = '0; Rd_Region = '0;
    cyc = 0;

    vecs[0] = '{12'h400, 12'h000, 1, 2};
    vecs[1] = '{12'h000, 12'h000, 0, 1};
    vecs[2] = '{12'hC00, 12'h800, 7, 0};
    vecs[3] = '{12'h800, 12'h000, 2, 3};
    vecs[4] = '{12'hC00, 12'h000, 3, 4};
    vecs[5] = '{12'h000, 12'h800, 4, 5};
    vecs[6] = '{12'h400, 12'h800, 5, 6};
    vecs[7] = '{12'h800, 12'hFFF, 6, 7};
    vecs[8] = '{12'h3FF, 12'h7FF, 0, 1};
    vecs[9] = '{12'hBFF, 12'h800, 6, 7};

    do_reset();

    // First press commits; repeated rises in LOCK and RELEASE are ignored.
    Touch_En = 1'b1; X_Coord = 12'h400; Y_Coord = 12'h000; Coord_En = 1'b1;
    tick();
    rd_check(1, 2, "t1_table1");
    check("t1_last",  int'(Last_Region), 1);
    check("t1_count", int'(Event_Count), 1);
    busy_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      Coord_En = (i % 3 == 1);
      tick();
      if (Busy) busy_cnt++;
    end
    for (int i = 0; i < 6; i++) begin
      Coord_En = (i % 3 == 1);
      tick();
    end
    check("t1_busy_cycles", busy_cnt, 16);
    rd_check(1, 2, "t2_table1_held");
    check("t2_busy_release", int'(Busy),        1);
    check("t2_count",        int'(Event_Count), 1);
    Touch_En = 1'b0; Coord_En = 1'b0;
    tick();
    check("t2_idle", int'(Busy), 0);

    // Host write coincident with a commit to the same region.
    Clear_Req = 1'b1; tick(); Clear_Req = 1'b0;
    Host_Wr = 1'b1; Host_Region = 3'd3; Host_Colour = 3'd5;
    X_Coord = 12'hC00; Y_Coord = 12'h000; Coord_En = 1'b1;
    tick();
    rd_check(3, 4, "t4_touch_first");
    check("t4_ack_blocked", int'(Host_Ack), 0);
    Coord_En = 1'b0;
    tick();
    rd_check(3, 5, "t4_host_second");
    check("t4_ack", int'(Host_Ack), 1);
    Host_Wr = 1'b0;
    tick();
    check("t4_ack_single", int'(Host_Ack), 0);

    // Clear during LOCK with a host write pending.
    Host_Region = 3'd6; Host_Colour = 3'd1; Host_Wr = 1'b1; Clear_Req = 1'b1;
    tick();
    check("t5_busy",  int'(Busy),        0);
    check("t5_count", int'(Event_Count), 0);
    check("t5_ack",   int'(Host_Ack),    0);
    check("t5_last",  int'(Last_Region), 3);
    check_table();
    Clear_Req = 1'b0;
    tick();
    check("t5_ack_after", int'(Host_Ack), 1);
    rd_check(6, 1, "t5_host_write");
    Host_Wr = 1'b0;
    tick();

    // Reset mid-LOCK with Coord_En held high commits on the first cycle after.
    X_Coord = 12'h400; Y_Coord = 12'h800; Coord_En = 1'b1; Touch_En = 1'b1;
    tick();
    repeat (5) tick();
    do_reset();
    tick();
    check("t6_count", int'(Event_Count), 1);
    check("t6_last",  int'(Last_Region), 5);
    check("t6_busy",  int'(Busy),        1);
    rd_check(5, 6, "t6_table5");
    Coord_En = 1'b0;
    wait_idle();

    // Region 7 wrap and Event_Count saturation.
    do_reset();
    X_Coord = 12'hC00; Y_Coord = 12'h800; Touch_En = 1'b0;
    touch();
    rd_check(7, 0, "t3_wrap");
    for (int i = 0; i < 259; i++) touch();
    check("t3_saturate", int'(Event_Count), 255);
    rd_check(7, 3, "t3_table7");

    // Region decode vectors, each from a cleared table.
    for (int v = 0; v < 10; v++) begin
      Clear_Req = 1'b1; tick(); Clear_Req = 1'b0;
      X_Coord = vecs[v].x; Y_Coord = vecs[v].y; Coord_En = 1'b1;
      tick();
      check("vec_last", int'(Last_Region), vecs[v].region);
      rd_check(vecs[v].region, vecs[v].colour, "vec_colour");
      Coord_En = 1'b0;
    end

    // Randomized traffic.
    Clear_Req = 1'b1; tick(); Clear_Req = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      Coord_En    = ($urandom_range(0, 2) == 0);
      Touch_En    = ($urandom_range(0, 3) != 0);
      X_Coord     = 12'($urandom);
      Y_Coord     = 12'($urandom);
      Clear_Req   = ($urandom_range(0, 59) == 0);
      Host_Wr     = ($urandom_range(0, 3) == 0);
      Host_Region = 3'($urandom);
      Host_Colour = 3'($urandom);
      Rd_Region   = 3'($urandom);
      tick();
    end
    Coord_En = 1'b0; Clear_Req = 1'b0; Host_Wr = 1'b0; Touch_En = 1'b0;
    tick();
    check_table();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
